// File: rtl/mbank_pkg.sv
// Shared constants and types for the multi-bank access scheduler.
package mbank_pkg;

    localparam int BANK_BITS  = 2;
    localparam int LOCAL_BITS = 3;
    localparam int ADDR_W     = BANK_BITS + LOCAL_BITS;
    localparam int DATA_W     = 8;
    localparam int NUM_PORTS  = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    // Tag carried alongside an in-flight read so the response finds its port.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    // Outstanding write: blocks reads to the same address until it ages out.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } sb_entry_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mbank_rr_arbiter.sv
// Two-requester round-robin arbiter: the port not granted most recently wins a tie.
module mbank_rr_arbiter
    import mbank_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] elig,
    output logic [NUM_PORTS-1:0] grant
);

    // Index of the port granted most recently; reset to B so that A is preferred.
    logic last_q;
    logic last_d;

    // Pick the grant and work out the pointer for the next cycle.
    always_comb begin
        if (elig == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end else begin
            grant = elig;
        end
        last_d = last_q;
        if (grant[0]) begin
            last_d = 1'b0;
        end else if (grant[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer only moves when a grant is actually given.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mbank_access_scheduler.sv
// Two-port front end for a pipelined RAM: arbitration, RAW stall, read return and drain.
module mbank_access_scheduler
    import mbank_pkg::*;
#(
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_valid,
    output logic [NUM_PORTS-1:0]                req_ready,
    input  logic [NUM_PORTS-1:0]                req_we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]                rsp_valid,
    output logic [DATA_W-1:0]                   rsp_rdata,
    output logic                                mem_en,
    output logic                                mem_we,
    output logic [ADDR_W-1:0]                   mem_addr,
    output logic [DATA_W-1:0]                   mem_din,
    input  logic [DATA_W-1:0]                   mem_dout,
    input  logic                                drain_req,
    output logic                                drain_done
);

    localparam int SB_N = WRITE_LATENCY + 1;

    state_e                     state_q, state_d;
    sb_entry_t [SB_N-1:0]       sb_q, sb_d;
    rd_tag_t [READ_LATENCY-1:0] rp_q, rp_d;
    logic [NUM_PORTS-1:0]       rsp_valid_q, rsp_valid_d;
    logic                       mem_en_q, mem_en_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]          mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]          mem_din_q, mem_din_d;

    logic                       run;
    logic [NUM_PORTS-1:0]       hazard;
    logic [NUM_PORTS-1:0]       elig;
    logic [NUM_PORTS-1:0]       grant;
    logic                       acc;
    logic                       gidx;
    logic                       sb_busy;
    logic                       rp_busy;

    // Requests are only taken in RUN, and never while reset is held.
    assign run = (state_q == ST_RUN) && !rst;

    // Compare each port's address with every outstanding write; also flag non-empty pipes.
    always_comb begin
        hazard  = '0;
        sb_busy = 1'b0;
        rp_busy = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int k = 0; k < SB_N; k++) begin
                if (sb_q[k].valid && (sb_q[k].addr == req_addr[p])) begin
                    hazard[p] = 1'b1;
                end
            end
        end
        for (int k = 0; k < SB_N; k++) begin
            sb_busy = sb_busy | sb_q[k].valid;
        end
        for (int k = 0; k < READ_LATENCY; k++) begin
            rp_busy = rp_busy | rp_q[k].valid;
        end
    end

    // A read colliding with an outstanding write waits; writes are always eligible.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
        assign elig[gi] = run && req_valid[gi] && (req_we[gi] || !hazard[gi]);
    end

    mbank_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .elig  (elig),
        .grant (grant)
    );

    assign req_ready = grant;
    assign acc       = |grant;
    assign gidx      = grant[1];

    // Head of each shift pipe is loaded on the same edge that launches the RAM command.
    assign sb_d[0] = {acc && req_we[gidx], req_addr[gidx]};
    assign rp_d[0] = {acc && !req_we[gidx], gidx};

    for (genvar gi = 1; gi < SB_N; gi++) begin : g_sb_shift
        assign sb_d[gi] = sb_q[gi-1];
    end

    for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_rp_shift
        assign rp_d[gi] = rp_q[gi-1];
    end

    // Next state, RAM command and response strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req)            state_d = ST_DRAIN;
            ST_DRAIN: if (!sb_busy && !rp_busy) state_d = ST_IDLE;
            ST_IDLE:  if (!drain_req)           state_d = ST_RUN;
            default:                            state_d = ST_RUN;
        endcase
        mem_en_d    = acc;
        mem_we_d    = acc && req_we[gidx];
        mem_addr_d  = acc ? req_addr[gidx]  : mem_addr_q;
        mem_din_d   = acc ? req_wdata[gidx] : mem_din_q;
        rsp_valid_d = rp_q[READ_LATENCY-1].valid ? port_onehot(rp_q[READ_LATENCY-1].port) : 2'b00;
    end

    // All state, including the registered outputs; reset drops any in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            sb_q        <= '0;
            rp_q        <= '0;
            rsp_valid_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            sb_q        <= sb_d;
            rp_q        <= rp_d;
            rsp_valid_q <= rsp_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = (|rsp_valid_q) ? mem_dout : '0;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign drain_done = (state_q == ST_IDLE);

endmodule
